// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout and input port numbering.
package noc_pkg;

    localparam int DATA_W = 7;
    localparam int ADDR_W = 4;
    localparam int FLIT_W = DATA_W + ADDR_W;
    localparam int SRC_W  = 3;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } flit_t;

    // Input ordering mirrors the path-computation output ordering.
    localparam int PORT_R1   = 0;
    localparam int PORT_R2   = 1;
    localparam int PORT_R3   = 2;
    localparam int PORT_R4   = 3;
    localparam int PORT_CORE = 4;

endpackage

// File: rtl/noc_input_arbiter_rr_arbiter.sv
// Round-robin arbiter: rotating-priority search starting at rr_ptr.
// The pointer moves past the winner only when the winner is accepted.
module rr_arbiter #(
    parameter int NUM_IN = 5,
    parameter int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IN-1:0] req,
    input  logic              advance,
    output logic              gnt_valid,
    output logic [IDX_W-1:0]  gnt_idx
);

    logic [IDX_W-1:0] r_ptr;
    logic             w_gnt_valid;
    logic [IDX_W-1:0] w_gnt_idx;

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        int j;
        j           = 0;
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            j = int'(r_ptr) + k;
            if (j >= NUM_IN) begin
                j = j - NUM_IN;
            end
            if (req[j]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = IDX_W'(j);
            end
        end
    end

    // Pointer moves to the port after the accepted winner; idle cycles hold it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (advance && w_gnt_valid) begin
            if (w_gnt_idx == IDX_W'(NUM_IN - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_gnt_idx + 1'b1;
            end
        end
    end

    assign gnt_valid = w_gnt_valid;
    assign gnt_idx   = w_gnt_idx;

endmodule

// File: rtl/noc_input_arbiter.sv
// Merge stage: round-robin selects one of the router links or the core
// injection port and forwards its packet through a single output register.
// Packets pass unmodified; the address field is never inspected.
module noc_input_arbiter
    import noc_pkg::*;
#(
    parameter int WIDTH  = 11,
    parameter int NUM_IN = 5,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SRC_W-1:0]        out_src,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        pkt_count
);

    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_data;
    logic [SRC_W-1:0]    r_out_src;
    logic [CNT_W-1:0]    r_pkt_count;

    logic                w_can_load;
    logic                w_load;
    logic                w_gnt_valid;
    logic [IDX_W-1:0]    w_gnt_idx;
    logic [NUM_IN-1:0]   w_in_ready;

    assign w_can_load = !r_out_valid || out_ready;
    assign w_load     = w_can_load && w_gnt_valid;

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (in_valid),
        .advance   (w_load),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    // One-hot ready to the granted port; rst_n gates it so nothing is offered during reset.
    always_comb begin
        w_in_ready = '0;
        if (rst_n && w_load) begin
            w_in_ready[w_gnt_idx] = 1'b1;
        end
    end

    // Output register: load wins over handoff so a same-edge replace keeps out_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data[w_gnt_idx*WIDTH +: WIDTH];
            r_out_src   <= SRC_W'(w_gnt_idx);
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Counts downstream handoffs; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_count <= '0;
        end else if (r_out_valid && out_ready) begin
            r_pkt_count <= r_pkt_count + 1'b1;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_noc_input_arbiter.sv
// Directed bench with a reference model and an expected-packet scoreboard.
module tb_noc_input_arbiter;
    import noc_pkg::*;

    localparam int W     = 11;
    localparam int N     = 5;
    localparam int CW    = 4;
    localparam int CMOD  = 1 << CW;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      in_valid;
    logic [N*W-1:0]    in_data;
    logic [N-1:0]      in_ready;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [2:0]        out_src;
    logic              out_ready;
    logic [CW-1:0]     pkt_count;

    noc_input_arbiter #(.WIDTH(W), .NUM_IN(N), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .pkt_count (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // model state
    int          m_ptr;
    bit          m_ov;
    int          m_cnt;
    bit          keep_valid;
    logic [13:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_ov  = 1'b0;
        m_cnt = 0;
        sb.delete();
    endtask

    // One clock of traffic: check pre-edge state against the model, then advance.
    task automatic step();
        bit          can;
        int          g;
        logic [N-1:0] exp_rdy;
        logic [13:0] e;
        bit          xfer;
        @(negedge clk);
        can = !m_ov || out_ready;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (in_valid[j] && g < 0) g = j;
        end
        exp_rdy = '0;
        if (can && g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("pkt_count", 32'(pkt_count), 32'(m_cnt));
        if (m_ov && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(e[10:0]));
                chk("out_src", 32'(out_src), 32'(e[13:11]));
            end
            m_cnt = (m_cnt + 1) % CMOD;
        end
        xfer = can && (g >= 0);
        if (xfer) begin
            sb.push_back({3'(g), in_data[g*W +: W]});
            m_ptr = (g + 1) % N;
            m_ov  = 1'b1;
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
        if (xfer) begin
            if (keep_valid) in_data[g*W +: W] = W'($urandom_range(0, 2047));
            else            in_valid[g] = 1'b0;
        end
    endtask

    task automatic put(input int p, input logic [W-1:0] d);
        in_data[p*W +: W] = d;
        in_valid[p] = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        flit_t f;
        rst_n      = 1'b0;
        in_valid   = '0;
        in_data    = '0;
        out_ready  = 1'b0;
        keep_valid = 1'b0;
        model_reset();

        // reset state with requests present
        #3;
        in_valid = '1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_src", 32'(out_src), 32'd0);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single request on port 2, visible one cycle after transfer
        f.data = 7'b1111000;
        f.addr = 4'b0100;
        out_ready = 1'b1;
        put(PORT_R3, f);
        step();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'h784);
        chk("t1_src", 32'(out_src), 32'd2);
        step();

        // all ports streaming: grants rotate 0..4 from a fresh pointer
        do_reset();
        keep_valid = 1'b1;
        for (int p = 0; p < N; p++) put(p, W'($urandom_range(0, 2047)));
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t2_order", 32'(out_src), 32'(i % N));
        end
        keep_valid = 1'b0;
        in_valid = '0;
        step();
        chk("t2_count10", 32'(pkt_count), 32'd10);

        // backpressure: port 1 held, port 3 loaded on the releasing edge
        put(PORT_R2, 11'h2A5);
        put(PORT_R4, 11'h15A);
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_hold_data", 32'(out_data), 32'h2A5);
            chk("t3_hold_rdy", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("t3_replace_valid", 32'(out_valid), 32'd1);
        chk("t3_replace_src", 32'(out_src), 32'd3);
        step();

        // pointer wrap after the core port
        f.data = 7'b0000001;
        f.addr = 4'b1000;
        put(PORT_CORE, f);
        step();
        chk("t4_core_src", 32'(out_src), 32'd4);
        chk("t4_core_data", 32'(out_data), 32'h018);
        put(PORT_R1, 11'h0F0);
        put(PORT_R4, 11'h70F);
        step();
        chk("t4_first", 32'(out_src), 32'd0);
        step();
        chk("t4_second", 32'(out_src), 32'd3);
        step();

        // sparse traffic: idle cycles leave the pointer at 4
        put(PORT_R4, 11'h333);
        step();
        for (int i = 0; i < 3; i++) step();
        put(PORT_R4, 11'h444);
        put(PORT_R1, 11'h555);
        step();
        chk("t6_first", 32'(out_src), 32'd0);
        step();
        chk("t6_second", 32'(out_src), 32'd3);
        step();

        // counter wrap
        keep_valid = 1'b1;
        put(PORT_R1, 11'h001);
        for (int i = 0; i < 40 && m_cnt != CMOD - 1; i++) step();
        keep_valid = 1'b0;
        in_valid = '0;
        chk("t5_at_max", 32'(pkt_count), 32'(CMOD - 1));
        step();
        chk("t5_wrapped", 32'(pkt_count), 32'd0);

        // reset mid-operation with a held packet
        out_ready = 1'b0;
        put(PORT_R3, 11'h222);
        step();
        step();
        chk("t7_held", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_valid", 32'(out_valid), 32'd0);
        chk("t7_rst_count", 32'(pkt_count), 32'd0);
        chk("t7_rst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        in_valid = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        put(PORT_CORE, 11'h7FF);
        put(PORT_R2, 11'h123);
        step();
        chk("t7_restart", 32'(out_src), 32'd1);
        step();
        chk("t7_next", 32'(out_src), 32'd4);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
